// File: rtl/tb_doutb_rsa_feed_pkg.sv
// ---------------------------------------------------------------------------
// tb_doutb_rsa_feed_pkg
// Constants shared by the systolic-array-to-TB write mapper and the TB port B
// read feeder: lane-mapping direction codes, NEW-landmark half select values
// and the feeder FSM state encodings.
// ---------------------------------------------------------------------------
package tb_doutb_rsa_feed_pkg;

    typedef logic [1:0] dir_t;

    // Lane mapping select
    localparam dir_t DIR_IDLE = 2'b00;
    localparam dir_t DIR_POS  = 2'b01;
    localparam dir_t DIR_NEG  = 2'b10;
    localparam dir_t DIR_NEW  = 2'b11;

    // NEW-landmark half select (value of l_k_0)
    localparam logic DIR_NEW_0 = 1'b0;   // A lanes 0,1 <- TB lanes 2,3
    localparam logic DIR_NEW_1 = 1'b1;   // A lanes 0,1 <- TB lanes 0,1

    // Feeder FSM states
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] DRAIN = 2'b10;

    // Mapping configuration latched when a burst is accepted
    typedef struct packed {
        dir_t dir;
        logic l_k_0;
    } map_cfg_t;

endpackage

// File: rtl/tb_doutb_rsa_feed_if.sv
// ---------------------------------------------------------------------------
// tb_doutb_rsa_feed_if
// Temp buffer (TB) BRAM port B read bus.
//   TB_enb    read enable          (feeder -> BRAM)
//   TB_addrb  row address          (feeder -> BRAM)
//   TB_doutb  row data, L lanes    (BRAM -> feeder), valid RD_LAT cycles
//             after the enable/address cycle
// Modports: master = read sequencer, slave = BRAM.
// ---------------------------------------------------------------------------
interface tb_doutb_rsa_feed_if #(
    parameter int L      = 4,
    parameter int RSA_DW = 16,
    parameter int TB_AW  = 10
);
    logic                  TB_enb;
    logic [TB_AW-1:0]      TB_addrb;
    logic [L*RSA_DW-1:0]   TB_doutb;

    modport master (
        output TB_enb,
        output TB_addrb,
        input  TB_doutb
    );

    modport slave (
        input  TB_enb,
        input  TB_addrb,
        output TB_doutb
    );
endinterface

// File: rtl/tb_doutb_rsa_feed_rsa_lane_skew.sv
// ---------------------------------------------------------------------------
// rsa_lane_skew
// Per-lane delay line that turns an aligned X-lane word into a diagonal
// wavefront: lane i (data and valid) is delayed by i cycles. Lane 0 is a
// pass-through. Only instantiated when TB_DOUTB_SKEW_EN is defined.
// Ports:
//   clk    clock
//   rst_n  asynchronous reset, active-low (clears every delay stage)
//   din    X lanes of DW-bit data, aligned
//   vin    per-lane valid, aligned
//   dout   skewed lane data
//   vout   skewed per-lane valid
// ---------------------------------------------------------------------------
module rsa_lane_skew #(
    parameter int X  = 4,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [X*DW-1:0] din,
    input  logic [X-1:0]    vin,
    output logic [X*DW-1:0] dout,
    output logic [X-1:0]    vout
);

    assign dout[DW-1:0] = din[DW-1:0];
    assign vout[0]      = vin[0];

    for (genvar i = 1; i < X; i++) begin : g_lane
        logic [DW-1:0] d_sr [i];
        logic [i-1:0]  v_sr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < i; k++) begin
                    d_sr[k] <= '0;
                end
                v_sr <= '0;
            end else begin
                d_sr[0] <= din[i*DW +: DW];
                v_sr[0] <= vin[i];
                for (int k = 1; k < i; k++) begin
                    d_sr[k] <= d_sr[k-1];
                    v_sr[k] <= v_sr[k-1];
                end
            end
        end

        assign dout[i*DW +: DW] = d_sr[i-1];
        assign vout[i]          = v_sr[i-1];
    end

endmodule

// File: rtl/tb_doutb_rsa_feed.sv
// ---------------------------------------------------------------------------
// tb_doutb_rsa_feed
// Sequences burst reads from TB port B and undoes the write-side lane mapping
// (POS / NEG / NEW) before presenting X operand lanes to the RSA input edge.
// Address -> A lane 0 latency is RD_LAT+1 cycles (BRAM latency plus one
// mapping register).
//
// Build option: TB_DOUTB_SKEW_EN
//   defined   - lane i is delayed i extra cycles (diagonal wavefront) and
//               the drain phase is extended by X-1 cycles.
//   undefined - all lanes aligned, no delay registers.
//
// Ports:
//   clk, sys_rst_n     clock, asynchronous active-low reset
//   start              one-cycle burst request, honoured only when idle
//   dir, l_k_0         mapping select / NEW-landmark half, latched on start
//   base_addr, len     first row and row count, latched on start
//   busy               burst in progress
//   done               one-cycle pulse after the last lane's last valid
//   tb_b               TB port B read bus (master side)
//   A_data, A_valid    mapped lane data and per-lane valid to the RSA
// ---------------------------------------------------------------------------
module tb_doutb_rsa_feed
    import tb_doutb_rsa_feed_pkg::*;
#(
    parameter int X      = 4,
    parameter int L      = 4,
    parameter int RSA_DW = 16,
    parameter int TB_AW  = 10,
    parameter int RD_LAT = 2,
    parameter int LEN_W  = 8
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    input  logic                 start,
    input  logic [1:0]           dir,
    input  logic                 l_k_0,
    input  logic [TB_AW-1:0]     base_addr,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    tb_doutb_rsa_feed_if.master  tb_b,
    output logic [X*RSA_DW-1:0]  A_data,
    output logic [X-1:0]         A_valid
);

`ifdef TB_DOUTB_SKEW_EN
    localparam int SKEW = X - 1;
`else
    localparam int SKEW = 0;
`endif
    // Cycles from the last read address until the last lane's last valid
    localparam int D   = RD_LAT + 1 + SKEW;
    localparam int DCW = $clog2(D + 1);

    logic [1:0]       state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic [TB_AW-1:0] addr;
    logic [DCW-1:0]   dcnt;
    map_cfg_t         cfg_q;
    logic             accept;

    // A start coinciding with done is dropped so the previous burst's
    // completion is always observed as a separate cycle.
    assign accept = start && (state == IDLE) && !done;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            len_q <= '0;
            addr  <= '0;
            dcnt  <= '0;
            cfg_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cfg_q.dir   <= dir;
                        cfg_q.l_k_0 <= l_k_0;
                        len_q       <= len;
                        addr        <= base_addr;
                        cnt         <= '0;
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    addr <= addr + 1'b1;   // wraps modulo 2^TB_AW
                    cnt  <= cnt + 1'b1;
                    if (cnt == len_q - 1'b1) begin
                        state <= DRAIN;
                        dcnt  <= DCW'(D - 1);
                    end
                end
                DRAIN: begin
                    if (dcnt == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign tb_b.TB_enb   = (state == READ);
    assign tb_b.TB_addrb = (state == READ) ? addr : '0;

    // ---- stage p0: TB_doutb qualified by the delayed read enable ----
    logic [RD_LAT-1:0]   rd_vld;
    logic                vld_p0;
    logic [X*RSA_DW-1:0] map_p0;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_vld <= '0;
        end else begin
            rd_vld[0] <= tb_b.TB_enb;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_vld[k] <= rd_vld[k-1];
            end
        end
    end

    assign vld_p0 = rd_vld[RD_LAT-1];

    for (genvar i = 0; i < X; i++) begin : g_map
        logic [RSA_DW-1:0] pos_v;
        logic [RSA_DW-1:0] neg_v;
        logic [RSA_DW-1:0] new_v;

        if (i < L) begin : g_pos
            assign pos_v = tb_b.TB_doutb[i*RSA_DW +: RSA_DW];
        end else begin : g_pos0
            assign pos_v = '0;
        end

        if (X - 1 - i < L) begin : g_neg
            assign neg_v = tb_b.TB_doutb[(X-1-i)*RSA_DW +: RSA_DW];
        end else begin : g_neg0
            assign neg_v = '0;
        end

        // NEW mapping only populates A lanes 0 and 1
        if (i < 2 && i + 2 < L) begin : g_new
            assign new_v = (cfg_q.l_k_0 == DIR_NEW_0)
                         ? tb_b.TB_doutb[(i+2)*RSA_DW +: RSA_DW]
                         : tb_b.TB_doutb[i*RSA_DW +: RSA_DW];
        end else begin : g_new0
            assign new_v = '0;
        end

        // Invalid rows are zeroed here so data is 0 whenever valid is 0
        assign map_p0[i*RSA_DW +: RSA_DW] =
            !vld_p0                   ? '0    :
            (cfg_q.dir == DIR_POS)    ? pos_v :
            (cfg_q.dir == DIR_NEG)    ? neg_v :
            (cfg_q.dir == DIR_NEW)    ? new_v : '0;
    end

    // ---- stage p1: mapping register ----
    logic [X*RSA_DW-1:0] data_p1;
    logic                vld_p1;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            data_p1 <= map_p0;
            vld_p1  <= vld_p0;
        end
    end

    // ---- stage p2: optional diagonal skew to the RSA edge ----
`ifdef TB_DOUTB_SKEW_EN
    rsa_lane_skew #(
        .X  (X),
        .DW (RSA_DW)
    ) u_skew (
        .clk   (clk),
        .rst_n (sys_rst_n),
        .din   (data_p1),
        .vin   ({X{vld_p1}}),
        .dout  (A_data),
        .vout  (A_valid)
    );
`else
    assign A_data  = data_p1;
    assign A_valid = {X{vld_p1}};
`endif

endmodule

// File: tb/tb_tb_doutb_rsa_feed.sv
// ---------------------------------------------------------------------------
// tb_tb_doutb_rsa_feed
// Self-checking bench for tb_doutb_rsa_feed: a BRAM model with RD_LAT read
// latency, a table of directed bursts, hand-written corner sequences and a
// randomized burst loop, all checked cycle by cycle against a timing model
// derived from the block's latency rules.
// ---------------------------------------------------------------------------
module tb_tb_doutb_rsa_feed;
    localparam int X      = 4;
    localparam int L      = 4;
    localparam int RSA_DW = 16;
    localparam int TB_AW  = 10;
    localparam int RD_LAT = 2;
    localparam int LEN_W  = 8;
`ifdef TB_DOUTB_SKEW_EN
    localparam int SKEW = X - 1;
`else
    localparam int SKEW = 0;
`endif

    logic                clk;
    logic                sys_rst_n;
    logic                start;
    logic [1:0]          dir;
    logic                l_k_0;
    logic [TB_AW-1:0]    base_addr;
    logic [LEN_W-1:0]    len;
    logic                busy;
    logic                done;
    logic [X*RSA_DW-1:0] A_data;
    logic [X-1:0]        A_valid;

    tb_doutb_rsa_feed_if #(.L(L), .RSA_DW(RSA_DW), .TB_AW(TB_AW)) tbif ();

    tb_doutb_rsa_feed #(
        .X(X), .L(L), .RSA_DW(RSA_DW), .TB_AW(TB_AW), .RD_LAT(RD_LAT), .LEN_W(LEN_W)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .dir       (dir),
        .l_k_0     (l_k_0),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .tb_b      (tbif),
        .A_data    (A_data),
        .A_valid   (A_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: row data appears RD_LAT cycles after the enable cycle;
    // non-enabled cycles return junk so unqualified data is visible.
    logic [L*RSA_DW-1:0] mem     [1<<TB_AW];
    logic [L*RSA_DW-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        rd_pipe[0] <= tbif.TB_enb ? mem[tbif.TB_addrb] : 64'hBAD0_BAD1_BAD2_BAD3;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign tbif.TB_doutb = rd_pipe[RD_LAT-1];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Lane unmapping rule, lanes as plain arrays
    function automatic logic [63:0] ref_map(input logic [63:0] row, input logic [1:0] d, input logic lk);
        logic [15:0] src [4];
        logic [15:0] dst [4];
        for (int j = 0; j < 4; j++) begin
            src[j] = row[j*16 +: 16];
            dst[j] = 16'h0;
        end
        case (d)
            2'b01: for (int j = 0; j < 4; j++) dst[j] = src[j];
            2'b10: for (int j = 0; j < 4; j++) dst[j] = src[3-j];
            2'b11: begin
                dst[0] = lk ? src[0] : src[2];
                dst[1] = lk ? src[1] : src[3];
            end
            default: ;
        endcase
        return {dst[3], dst[2], dst[1], dst[0]};
    endfunction

    // Row index visible on lane i, t cycles after the accepting edge
    function automatic int row_at(input int t, input int i);
        return t - (RD_LAT + 2) - ((SKEW > 0) ? i : 0);
    endfunction

    function automatic logic [X-1:0] exp_vld(input int t, input int n);
        logic [X-1:0] v;
        v = '0;
        for (int i = 0; i < X; i++) v[i] = (row_at(t, i) >= 0) && (row_at(t, i) < n);
        return v;
    endfunction

    function automatic logic [63:0] pat(input logic [TB_AW-1:0] a);
        logic [63:0] p;
        for (int j = 0; j < 4; j++) p[j*16 +: 16] = 16'({a, 2'b00}) + 16'(j);
        return p;
    endfunction

    // Issue one burst from an idle cycle and check every cycle up to and
    // including done. poke: 0 none, -1 start in the done cycle, >0 start at t.
    // Returns in the cycle after done, just past the clock edge.
    task automatic run_burst(input logic [1:0] d, input logic lk, input logic [TB_AW-1:0] b,
                             input int n, input int poke, output logic [63:0] got0);
        int done_t, pk, r;
        logic [63:0] ed, row;
        logic [X-1:0] ev;
        logic [TB_AW-1:0] ea;
        logic en;
        got0 = '0;
        done_t = (n == 0) ? 1 : n + RD_LAT + 2 + SKEW;
        pk = (poke < 0) ? done_t : poke;
        start = 1'b1; dir = d; l_k_0 = lk; base_addr = b; len = LEN_W'(n);
        @(posedge clk); #1;
        for (int t = 1; t <= done_t; t++) begin
            start     = (t == pk);
            dir       = 2'($urandom);
            l_k_0     = 1'($urandom);
            base_addr = TB_AW'($urandom);
            len       = LEN_W'($urandom_range(1, 20));
            en = (t <= n);
            ea = en ? b + TB_AW'(t - 1) : '0;
            ev = '0;
            ed = '0;
            for (int i = 0; i < X; i++) begin
                r = row_at(t, i);
                if (r >= 0 && r < n) begin
                    ev[i] = 1'b1;
                    row = ref_map(mem[b + TB_AW'(r)], d, lk);
                    ed[i*RSA_DW +: RSA_DW] = row[i*RSA_DW +: RSA_DW];
                end
            end
            @(negedge clk);
            chk($sformatf("enb t=%0d", t),  64'(tbif.TB_enb),   64'(en));
            chk($sformatf("addr t=%0d", t), 64'(tbif.TB_addrb), 64'(ea));
            chk($sformatf("busy t=%0d", t), 64'(busy),          64'((n > 0) && (t < done_t)));
            chk($sformatf("done t=%0d", t), 64'(done),          64'(t == done_t));
            chk($sformatf("vld t=%0d", t),  64'(A_valid),       64'(ev));
            chk($sformatf("data t=%0d", t), 64'(A_data),        ed);
            for (int i = 0; i < X; i++)
                if (ev[i] && row_at(t, i) == 0) got0[i*RSA_DW +: RSA_DW] = A_data[i*RSA_DW +: RSA_DW];
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [1:0]       d;
        logic             lk;
        logic [TB_AW-1:0] b;
        int               n;
        int               poke;
        logic [63:0]      row0;
        logic [63:0]      exp0;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [63:0] got0;
        logic [1:0]  rd;
        logic        rlk;
        logic [TB_AW-1:0] rb;
        int rn, rpk, gap;

        sys_rst_n = 1'b0; start = 1'b0; dir = 2'b00; l_k_0 = 1'b0;
        base_addr = '0; len = '0;
        for (int a = 0; a < (1 << TB_AW); a++) mem[a] = {$urandom, $urandom};

        tbl[0] = '{2'b01, 1'b0, 10'h010, 3, 0, 64'h0043_0042_0041_0040, 64'h0043_0042_0041_0040};
        tbl[1] = '{2'b10, 1'b0, 10'h100, 1, 0, 64'h000D_000C_000B_000A, 64'h000A_000B_000C_000D};
        tbl[2] = '{2'b11, 1'b0, 10'h200, 1, 0, 64'h0004_0003_0002_0001, 64'h0000_0000_0004_0003};
        tbl[3] = '{2'b11, 1'b1, 10'h200, 1, 0, 64'h0004_0003_0002_0001, 64'h0000_0000_0002_0001};
        tbl[4] = '{2'b00, 1'b0, 10'h080, 2, 0, 64'h1111_2222_3333_4444, 64'h0000_0000_0000_0000};
        tbl[5] = '{2'b01, 1'b0, 10'h3FE, 4, 2, 64'h0BAD_0CAB_0FEE_0DAD, 64'h0BAD_0CAB_0FEE_0DAD};
        tbl[6] = '{2'b10, 1'b1, 10'h055, 0, 0, 64'h0001_0002_0003_0004, 64'h0000_0000_0000_0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy",  64'(busy),          64'd0);
        chk("reset done",  64'(done),          64'd0);
        chk("reset enb",   64'(tbif.TB_enb),   64'd0);
        chk("reset addr",  64'(tbif.TB_addrb), 64'd0);
        chk("reset vld",   64'(A_valid),       64'd0);
        chk("reset data",  64'(A_data),        64'd0);
        sys_rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int k = 0; k < 7; k++) begin
            for (int r = 0; r < tbl[k].n; r++) mem[tbl[k].b + TB_AW'(r)] = pat(tbl[k].b + TB_AW'(r));
            mem[tbl[k].b] = tbl[k].row0;
            run_burst(tbl[k].d, tbl[k].lk, tbl[k].b, tbl[k].n, tbl[k].poke, got0);
            if (tbl[k].n != 0) chk($sformatf("row0 vec%0d", k), got0, tbl[k].exp0);
            start = 1'b0;
            @(posedge clk); #1;
        end

        // Start in the done cycle is ignored
        run_burst(2'b01, 1'b0, 10'h123, 2, -1, got0);
        start = 1'b0;
        @(negedge clk);
        chk("post-done busy", 64'(busy),        64'd0);
        chk("post-done enb",  64'(tbif.TB_enb), 64'd0);
        @(posedge clk); #1;

        // Back-to-back: start in the cycle right after done
        run_burst(2'b10, 1'b0, 10'h2A0, 2, 0, got0);
        run_burst(2'b11, 1'b1, 10'h2B0, 3, 0, got0);
        start = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of READ
        start = 1'b1; dir = 2'b01; l_k_0 = 1'b0; base_addr = 10'h020; len = 8'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("mid enb",  64'(tbif.TB_enb),   64'd1);
        chk("mid addr", 64'(tbif.TB_addrb), 64'h024);
        chk("mid vld",  64'(A_valid),       64'(exp_vld(5, 6)));
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async busy", 64'(busy),          64'd0);
        chk("async done", 64'(done),          64'd0);
        chk("async enb",  64'(tbif.TB_enb),   64'd0);
        chk("async addr", 64'(tbif.TB_addrb), 64'd0);
        chk("async vld",  64'(A_valid),       64'd0);
        chk("async data", 64'(A_data),        64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst hold done", 64'(done),    64'd0);
            chk("rst hold vld",  64'(A_valid), 64'd0);
        end
        sys_rst_n = 1'b1;
        @(posedge clk); #1;
        run_burst(2'b01, 1'b0, 10'h020, 6, 0, got0);
        start = 1'b0;
        @(posedge clk); #1;

        // Randomized bursts
        for (int it = 0; it < 24; it++) begin
            rd  = 2'($urandom);
            rlk = 1'($urandom);
            rb  = TB_AW'($urandom);
            rn  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
            if ($urandom_range(0, 3) == 0) rpk = -1;
            else if ($urandom_range(0, 1) == 0) rpk = 0;
            else rpk = int'($urandom_range(1, 6));
            run_burst(rd, rlk, rb, rn, rpk, got0);
            start = 1'b0;
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin @(posedge clk); #1; end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tb_doutb_rsa_feed.md
Name: tb_doutb_rsa_feed

Overview:
Read-side counterpart of the systolic-array-to-TB write mapper. It sequences burst reads from temp buffer (TB) port B and undoes the lane mapping applied on write (POS / NEG / NEW). It aligns for BRAM read latency and optionally skews the lanes diagonally into the RSA input edge. It sits between the TB BRAM port B and the RSA X-lane operand input, and is started by the top-level controller.

Parameters:
X, 4, RSA input lanes (the NEW mapping requires X>=2)
L, 4, TB data lanes (the NEW mapping requires L>=4)
RSA_DW, 16, lane data width
TB_AW, 10, TB port B address width
RD_LAT, 2, TB read latency in cycles from TB_enb/TB_addrb to TB_doutb valid (>=1)
LEN_W, 8, burst length counter width

Ports:
clk  in  1  system clock
sys_rst_n  in  1  asynchronous reset, active-low
start  in  1  one-cycle burst request; sampled only in IDLE
dir  in  2  mapping select: 00 IDLE, 01 POS, 10 NEG, 11 NEW
l_k_0  in  1  NEW-landmark half select
base_addr  in  TB_AW  first TB row address
len  in  LEN_W  number of rows to read
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the burst is fully delivered
TB_enb  out  1  TB port B read enable
TB_addrb  out  TB_AW  TB port B address
TB_doutb  in  L*RSA_DW  TB port B read data
A_data  out  X*RSA_DW  mapped lane data to the RSA
A_valid  out  X  per-lane valid

Behaviour:
- Reset (async, sys_rst_n=0): state=IDLE; busy, done, TB_enb, A_valid=0; TB_addrb, A_data=0; all pipeline and skew registers cleared. Reset asserted mid-burst aborts the burst with no done pulse.
- start, dir, l_k_0, base_addr and len are latched when start is accepted in IDLE. start while busy is ignored.
- FSM:
  - IDLE: on start with len!=0, go to READ. On start with len==0, pulse done on the next cycle and stay in IDLE.
  - READ: TB_enb=1, TB_addrb=base+cnt (modulo 2^TB_AW, wraps silently), cnt increments each cycle. When cnt==len-1, go to DRAIN.
  - DRAIN: TB_enb=0. Count down D = RD_LAT+1+SKEW cycles (SKEW = X-1 with the skew feature, else 0). When the last lane's last valid has been presented, pulse done, drop busy and return to IDLE. A start arriving in the same cycle as done is ignored; it may be accepted from the next cycle.
- Read valid: a shift register of depth RD_LAT tracks TB_enb. Its output qualifies TB_doutb.
- Mapping register: one registered stage, giving latency of address -> A lane 0 = RD_LAT+1 cycles. With latched dir:
  - POS: A lane i = TB lane i, for i<min(X,L).
  - NEG: A lane i = TB lane X-1-i.
  - NEW with l_k_0=1: A lanes 0,1 = TB lanes 0,1; other lanes 0.
  - NEW with l_k_0=0: A lanes 0,1 = TB lanes 2,3; other lanes 0.
  - IDLE: all lanes 0, but valids still propagate.
- Lanes forced to 0 by the mapping still carry valid.
- While a lane's valid is 0, its A_data is 0.

Optional Feature:
Macro TB_DOUTB_SKEW_EN.
- Defined: lane i passes through an i-stage delay line after the mapping register. A_valid[i] is A_valid[0] delayed by i cycles, forming the diagonal wavefront the systolic array needs. D includes X-1.
- Undefined: all lanes are aligned, A_valid is all-ones or all-zeros together, and no delay registers are built.

Decomposition:
- Shared package holds DIR_IDLE/DIR_POS/DIR_NEG/DIR_NEW (2'b00..2'b11), DIR_NEW_0/DIR_NEW_1, and the FSM state encodings IDLE/READ/DRAIN. The write mapper and this block both use these constants.
- One sub-module, rsa_lane_skew: parameterised per-lane delay line (data + valid, lane i delayed i cycles, async active-low reset). It is instantiated only under TB_DOUTB_SKEW_EN.

Test Plan:
1. POS burst, no skew, RD_LAT=2, base=0x010, len=3, TB row r lanes = {r*4+3..r*4}:
   - TB_addrb 0x010..0x012 on consecutive cycles.
   - A_valid=4'hF for 3 cycles starting 3 cycles after the first address, with A_data matching the TB rows.
   - done pulses exactly once and busy falls in the same cycle.
2. NEG, skew on, one row {lane3..0}={D,C,B,A}:
   - A lane0=D at t0, lane1=C at t0+1, lane2=B at t0+2, lane3=A at t0+3.
   - done follows lane 3.
3. NEW, l_k_0=0, row {4,3,2,1}: A lanes {0,0,4,3} (lane3..0) with all 4 valids high. Repeat with l_k_0=1: {0,0,2,1}.
4. Boundary cases:
   - start with len=0 -> done pulses the next cycle and TB_enb never asserts.
   - base=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
   - start pulsed during a burst -> ignored, with no change to addresses or count.
5. sys_rst_n dropped mid-READ:
   - All outputs go to 0 immediately (asynchronously) and no done pulse occurs.
   - After release, a new start runs a clean burst.
6. Back-to-back bursts: start asserted in the cycle after done -> accepted, with no stale A_valid carried over from the previous burst.
